// File: rtl/instruction_fetch_queue.sv
// ---------------------------------------------------------------------------------------------
// instruction_fetch_queue
//
// Fetch front end for the 5-stage pipeline. Owns the fetch PC, issues one word-addressed request
// at a time to instruction memory (req/gnt/rvalid) and buffers returned instructions in a small
// FIFO presented to decode with valid/ready. Redirects flush the FIFO and discard the response of
// any request that is still in flight.
//
// Optional feature: define IFQ_BYPASS_EN to let a response go straight to instr_* in the cycle
// mem_rvalid arrives when the FIFO is empty. Without it there is no combinational path from mem_*
// to instr_*.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   mem_req        request valid (registered)
//   mem_addr       request word address (registered, stable until granted)
//   mem_gnt        memory accepts the request this cycle
//   mem_rvalid     response valid
//   mem_rdata      response instruction
//   instr_valid    head entry valid
//   instr          head instruction, 0 when not valid
//   instr_pc       address of the head instruction, 0 when not valid
//   instr_ready    decode accepts the head this cycle
//   redirect_valid branch taken / redirect
//   redirect_pc    new fetch address
//   queue_count    occupied FIFO entries
// ---------------------------------------------------------------------------------------------
module instruction_fetch_queue #(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     instr_valid,
    output logic [DATA_W-1:0]        instr,
    output logic [ADDR_W-1:0]        instr_pc,
    input  logic                     instr_ready,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic [$clog2(DEPTH):0]   queue_count
);

    localparam int unsigned     PtrW     = $clog2(DEPTH);
    localparam int unsigned     CntW     = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic                drop_q, drop_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]     count_q, count_d;

    logic [DATA_W-1:0]   fifo_data_q [DEPTH];
    logic [ADDR_W-1:0]   fifo_pc_q   [DEPTH];

    logic fifo_empty;
    logic rsp_keep;
    logic push;
    logic pop;

    assign fifo_empty = (count_q == '0);

    // A response is kept only if it belongs to the current fetch stream and no redirect is
    // flushing the queue this cycle.
    assign rsp_keep = (state_q == StWait) & mem_rvalid & ~drop_q & ~redirect_valid;
    assign pop      = ~fifo_empty & instr_ready & ~redirect_valid;

`ifdef IFQ_BYPASS_EN
    logic bypass;
    assign bypass = fifo_empty & rsp_keep;
    // A bypassed response consumed by decode never enters the FIFO.
    assign push   = rsp_keep & ~(bypass & instr_ready);
`else
    assign push   = rsp_keep;
`endif

    // Head presentation
    always_comb begin
        instr_valid = ~fifo_empty;
        instr       = fifo_empty ? '0 : fifo_data_q[rd_ptr_q];
        instr_pc    = fifo_empty ? '0 : fifo_pc_q[rd_ptr_q];
`ifdef IFQ_BYPASS_EN
        if (bypass) begin
            instr_valid = 1'b1;
            instr       = mem_rdata;
            instr_pc    = mem_addr_q;
        end
`endif
    end

    // Request FSM
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        unique case (state_q)
            StIdle: begin
                // A redirect in IDLE only retargets the PC; issue starts next cycle from it.
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                end else if (count_q < DepthCnt) begin
                    state_d    = StReq;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end
            end
            StReq: begin
                if (mem_gnt) begin
                    state_d    = StWait;
                    mem_req_d  = 1'b0;
                    fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                end
                // The old request still completes; its response gets thrown away.
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                    drop_d     = 1'b1;
                end
            end
            StWait: begin
                if (mem_rvalid) begin
                    state_d = StIdle;
                    drop_d  = 1'b0;
                end
                // If the response returns in the redirect cycle it is already discarded by the
                // flush, so nothing is left in flight to drop.
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                    drop_d     = ~mem_rvalid;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FIFO pointers and occupancy
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            drop_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_rdata;
            fifo_pc_q[wr_ptr_q]   <= mem_addr_q;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign queue_count = count_q;

endmodule
